led_mode_ctrl: RTL



---
 rtl/led_ctrl_pkg.sv | 18 +
 rtl/btn_debounce.sv | 45 ++++
 rtl/led_mode_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the two-button / four-LED mode controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_LOGIC = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_t;

  localparam logic [3:0] CHASE_INIT = 4'b0001;

  // One chaser step; left moves the lit bit towards led_3.
  function automatic logic [3:0] chase_rotate(input logic [3:0] pattern, input logic right);
    return right ? {pattern[0], pattern[3:1]} : {pattern[2:0], pattern[3]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw button, debounces it and emits a one-cycle pulse on each debounced press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic db,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          db_q;
  logic [CW-1:0] cnt;

  // The counter only advances while the synchronised level disagrees with db, so any agreement restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      db     <= 1'b0;
      db_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      db_q   <= db;
      if (sync_b == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync_b;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = db & ~db_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Mode controller: btn_0 cycles LOGIC/COUNT/CHASE/HOLD, btn_1 is the per-mode action; LEDs are registered.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_0,
  input  logic       btn_1,
  output logic       led_0,
  output logic       led_1,
  output logic       led_2,
  output logic       led_3,
  output logic [1:0] mode
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic db0, db1, press0, press1, act;

  mode_t         mode_q, mode_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    pattern_q, pattern_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    led_q, led_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_0), .db(db0), .press(press0)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_1), .db(db1), .press(press1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= MODE_LOGIC;
      count_q   <= 4'd0;
      pattern_q <= CHASE_INIT;
      dir_q     <= 1'b0;
      tick_q    <= '0;
      led_q     <= 4'd0;
    end else begin
      mode_q    <= mode_d;
      count_q   <= count_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      led_q     <= led_d;
    end
  end

  // A mode press wins over a simultaneous action press, which is dropped.
  always_comb begin
    mode_d    = mode_q;
    count_d   = count_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    tick_d    = tick_q;
    led_d     = led_q;
    act       = press1 & ~press0;

    unique case (mode_q)
      MODE_LOGIC: led_d = {db0 | db1, db0 & db1, db1, db0};
      MODE_COUNT: begin
        led_d = count_q;
        if (act) count_d = count_q + 4'd1;
      end
      MODE_CHASE: begin
        led_d = pattern_q;
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          pattern_d = chase_rotate(pattern_q, dir_q);
        end else begin
          tick_d = tick_q + TW'(1);
        end
        if (act) dir_d = ~dir_q;
      end
      MODE_HOLD: begin
        if (act) led_d = 4'd0;
      end
    endcase

    // HOLD needs no capture register: led_q keeps whatever CHASE wrote on the transition edge.
    if (press0) begin
      mode_d = mode_t'(mode_q + 2'd1);
      if (mode_q == MODE_COUNT) begin
        pattern_d = CHASE_INIT;
        tick_d    = '0;
      end
    end
  end

  assign led_0 = led_q[0];
  assign led_1 = led_q[1];
  assign led_2 = led_q[2];
  assign led_3 = led_q[3];
  assign mode  = mode_q;

endmodule
